// File: rtl/hazard_control_if.sv
// Bundles the pipeline-status inputs and stage-control outputs of the hazard sequencer.
// master: the pipeline datapath, which reports status and receives latch controls.
// slave: the hazard_control block, which consumes status and drives controls.
interface hazard_control_if #(
  parameter int CNT_W = 16
);
  // ID/EX hazard sources
  logic [2:0]       id_read_r1;
  logic [2:0]       id_read_r2;
  logic             id_uses_r1;
  logic             id_uses_r2;
  logic [2:0]       ex_write_r;
  logic             ex_REG_WRITE;
  logic             ex_MEM_READ;
  logic             ex_redirect;
  // memory and halt status
  logic             mem_access;
  logic             dmem_done;
  logic             imem_stall;
  logic             wb_HALT;
  // stage controls
  logic             pc_en;
  logic             if_id_en;
  logic             if_id_flush;
  logic             id_ex_en;
  logic             id_ex_bubble;
  logic             ex_mem_en;
  logic             mem_wb_en;
  logic             mem_wb_bubble;
  logic             halted;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output id_read_r1, id_read_r2, id_uses_r1, id_uses_r2, ex_write_r,
           ex_REG_WRITE, ex_MEM_READ, ex_redirect, mem_access, dmem_done,
           imem_stall, wb_HALT,
    input  pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble, ex_mem_en,
           mem_wb_en, mem_wb_bubble, halted, stall_cnt
  );

  modport slave (
    input  id_read_r1, id_read_r2, id_uses_r1, id_uses_r2, ex_write_r,
           ex_REG_WRITE, ex_MEM_READ, ex_redirect, mem_access, dmem_done,
           imem_stall, wb_HALT,
    output pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble, ex_mem_en,
           mem_wb_en, mem_wb_bubble, halted, stall_cnt
  );
endinterface

// File: rtl/hazard_control.sv
// Pipeline sequencer: load-use stalls, redirect flushes, dmem/imem waits, halt, stall counter.
// Latency: stage controls are combinational from state+inputs (0 cycles); state/counter registered.
// Backpressure: a pending data-memory access freezes every latch until dmem_done.
module hazard_control #(
  parameter int CNT_W = 16
) (
  input logic           clk,
  input logic           rst_n,
  hazard_control_if.slave hc
);

  typedef enum logic [1:0] {RUN, DWAIT, HALT} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             stall_evt;
  logic             eval_flow;
  logic             load_use;

  logic pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble;
  logic ex_mem_en, mem_wb_en, mem_wb_bubble, halted;

  // A load in EX whose destination feeds a source the ID instruction really reads.
  // r0 is an ordinary register here, so a match on it still stalls.
  always_comb begin
    load_use = hc.ex_MEM_READ & hc.ex_REG_WRITE &
               ((hc.id_uses_r1 & (hc.ex_write_r == hc.id_read_r1)) |
                (hc.id_uses_r2 & (hc.ex_write_r == hc.id_read_r2)));
  end

  // Next-state and stage-control decode; reset overrides everything at the end.
  always_comb begin
    pc_en         = 1'b1;
    if_id_en      = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_en      = 1'b1;
    id_ex_bubble  = 1'b0;
    ex_mem_en     = 1'b1;
    mem_wb_en     = 1'b1;
    mem_wb_bubble = 1'b0;
    halted        = 1'b0;
    state_nxt     = state;
    stall_evt     = 1'b0;
    eval_flow     = 1'b0;

    case (state)
      RUN: begin
        if (hc.wb_HALT) begin
          {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = '0;
          state_nxt = HALT;
        end else if (hc.mem_access && !hc.dmem_done) begin
          {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = '0;
          state_nxt = DWAIT;
          stall_evt = 1'b1;
        end else begin
          eval_flow = 1'b1;
        end
      end
      DWAIT: begin
        // WB is frozen here, so wb_HALT is deliberately not looked at.
        if (!hc.dmem_done) begin
          {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = '0;
          stall_evt = 1'b1;
        end else begin
          // EX/ID contents were held through the freeze; act on them once now.
          state_nxt = RUN;
          eval_flow = 1'b1;
        end
      end
      HALT: begin
        {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = '0;
        halted = 1'b1;
      end
      default: begin
        state_nxt = RUN;
      end
    endcase

    // Front-end hazards; a redirect wins because IF/ID hold wrong-path instructions.
    if (eval_flow) begin
      if (hc.ex_redirect) begin
        if_id_flush  = 1'b1;
        id_ex_bubble = 1'b1;
      end else if (load_use) begin
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        id_ex_bubble = 1'b1;
        stall_evt    = 1'b1;
      end else if (hc.imem_stall) begin
        pc_en       = 1'b0;
        if_id_flush = 1'b1;
        stall_evt   = 1'b1;
      end
    end

    if (!rst_n) begin
      {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = '0;
      if_id_flush   = 1'b1;
      id_ex_bubble  = 1'b1;
      mem_wb_bubble = 1'b1;
      halted        = 1'b0;
      state_nxt     = RUN;
      stall_evt     = 1'b0;
    end
  end

  // FSM state and saturating stall counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (stall_evt && (cnt != {CNT_W{1'b1}})) begin
        cnt <= cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign hc.pc_en         = pc_en;
  assign hc.if_id_en      = if_id_en;
  assign hc.if_id_flush   = if_id_flush;
  assign hc.id_ex_en      = id_ex_en;
  assign hc.id_ex_bubble  = id_ex_bubble;
  assign hc.ex_mem_en     = ex_mem_en;
  assign hc.mem_wb_en     = mem_wb_en;
  assign hc.mem_wb_bubble = mem_wb_bubble;
  assign hc.halted        = halted;
  assign hc.stall_cnt     = cnt;

endmodule

// File: tb/tb_hazard_control.sv
// Testbench for hazard_control: scenario tasks with a queue of expected outputs.
// Inputs driven 1 ns after the rising edge, outputs sampled on the falling edge.
// A narrow counter (2 bits) makes saturation reachable in a few cycles.
module tb_hazard_control;
  localparam int CNT_W = 2;

  // control vector order: pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble,
  //                       ex_mem_en, mem_wb_en, mem_wb_bubble, halted
  localparam logic [8:0] C_RUN    = 9'b110101100;
  localparam logic [8:0] C_FRZ    = 9'b000000000;
  localparam logic [8:0] C_RST    = 9'b001010010;
  localparam logic [8:0] C_LU     = 9'b000111100;
  localparam logic [8:0] C_REDIR  = 9'b111111100;
  localparam logic [8:0] C_IMEM   = 9'b011101100;
  localparam logic [8:0] C_HALTED = 9'b000000001;

  typedef struct packed {
    logic       rst;
    logic [2:0] r1;
    logic [2:0] r2;
    logic       u1;
    logic       u2;
    logic [2:0] exw;
    logic       exrw;
    logic       exmr;
    logic       redir;
    logic       macc;
    logic       dd;
    logic       imem;
    logic       halt;
  } in_t;

  typedef struct packed {
    logic [8:0]       ctl;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  hazard_control_if #(.CNT_W(CNT_W)) hc ();

  hazard_control #(.CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hc    (hc)
  );

  function automatic in_t f_idle();
    in_t v;
    v     = '0;
    v.rst = 1'b1;
    return v;
  endfunction

  function automatic in_t f_lu(input logic [2:0] r1, input logic [2:0] r2,
                               input logic u1, input logic u2, input logic [2:0] exw);
    in_t v;
    v      = f_idle();
    v.r1   = r1;
    v.r2   = r2;
    v.u1   = u1;
    v.u2   = u2;
    v.exw  = exw;
    v.exrw = 1'b1;
    v.exmr = 1'b1;
    return v;
  endfunction

  function automatic in_t f_mem(input logic dd);
    in_t v;
    v      = f_idle();
    v.macc = 1'b1;
    v.dd   = dd;
    return v;
  endfunction

  function automatic logic [8:0] obs_ctl();
    return {hc.pc_en, hc.if_id_en, hc.if_id_flush, hc.id_ex_en, hc.id_ex_bubble,
            hc.ex_mem_en, hc.mem_wb_en, hc.mem_wb_bubble, hc.halted};
  endfunction

  task automatic drive(input in_t v);
    @(posedge clk);
    #1;
    rst_n           = v.rst;
    hc.id_read_r1   = v.r1;
    hc.id_read_r2   = v.r2;
    hc.id_uses_r1   = v.u1;
    hc.id_uses_r2   = v.u2;
    hc.ex_write_r   = v.exw;
    hc.ex_REG_WRITE = v.exrw;
    hc.ex_MEM_READ  = v.exmr;
    hc.ex_redirect  = v.redir;
    hc.mem_access   = v.macc;
    hc.dmem_done    = v.dd;
    hc.imem_stall   = v.imem;
    hc.wb_HALT      = v.halt;
  endtask

  task automatic apply(input in_t v, input logic [8:0] ctl, input logic [CNT_W-1:0] cnt);
    exp_t e;
    drive(v);
    e.ctl = ctl;
    e.cnt = cnt;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    in_t v;
    v     = f_idle();
    v.rst = 1'b0;
    drive(v);
  endtask

  task automatic test_reset();
    in_t v[3];
    logic [8:0] c[3];
    logic [CNT_W-1:0] n[3];
    exp_t e;
    v[0] = f_idle(); v[0].rst = 1'b0; c[0] = C_RST; n[0] = 2'd0;
    v[1] = f_idle(); v[1].rst = 1'b0; v[1].halt = 1'b1; c[1] = C_RST; n[1] = 2'd0;
    v[2] = f_idle(); c[2] = C_RUN; n[2] = 2'd0;
    for (int i = 0; i < 3; i++) begin
      apply(v[i], c[i], n[i]);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (obs_ctl() !== e.ctl) begin
        errors++;
        $display("FAIL reset[%0d] ctl got %b want %b", i, obs_ctl(), e.ctl);
      end
      checks++;
      if (hc.stall_cnt !== e.cnt) begin
        errors++;
        $display("FAIL reset[%0d] stall_cnt got %0d want %0d", i, hc.stall_cnt, e.cnt);
      end
    end
  endtask

  task automatic test_load_use();
    in_t v[5];
    logic [8:0] c[5];
    logic [CNT_W-1:0] n[5];
    exp_t e;
    v[0] = f_lu(3'd3, 3'd2, 1'b1, 1'b1, 3'd3); c[0] = C_LU;  n[0] = 2'd0;
    v[1] = f_idle();                           c[1] = C_RUN; n[1] = 2'd1;
    v[2] = f_lu(3'd5, 3'd4, 1'b1, 1'b1, 3'd4); c[2] = C_LU;  n[2] = 2'd1;
    v[3] = f_lu(3'd0, 3'd7, 1'b1, 1'b0, 3'd0); c[3] = C_LU;  n[3] = 2'd2;
    v[4] = f_idle();                           c[4] = C_RUN; n[4] = 2'd3;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      apply(v[i], c[i], n[i]);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (obs_ctl() !== e.ctl) begin
        errors++;
        $display("FAIL load_use[%0d] ctl got %b want %b", i, obs_ctl(), e.ctl);
      end
      checks++;
      if (hc.stall_cnt !== e.cnt) begin
        errors++;
        $display("FAIL load_use[%0d] stall_cnt got %0d want %0d", i, hc.stall_cnt, e.cnt);
      end
    end
  endtask

  task automatic test_no_stall();
    in_t v[4];
    logic [8:0] c[4];
    logic [CNT_W-1:0] n[4];
    exp_t e;
    v[0] = f_lu(3'd3, 3'd2, 1'b0, 1'b1, 3'd3);                  c[0] = C_RUN; n[0] = 2'd0;
    v[1] = f_lu(3'd3, 3'd2, 1'b1, 1'b1, 3'd3); v[1].exrw = 1'b0; c[1] = C_RUN; n[1] = 2'd0;
    v[2] = f_lu(3'd3, 3'd2, 1'b1, 1'b1, 3'd3); v[2].exmr = 1'b0; c[2] = C_RUN; n[2] = 2'd0;
    v[3] = f_idle();                                             c[3] = C_RUN; n[3] = 2'd0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      apply(v[i], c[i], n[i]);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (obs_ctl() !== e.ctl) begin
        errors++;
        $display("FAIL no_stall[%0d] ctl got %b want %b", i, obs_ctl(), e.ctl);
      end
      checks++;
      if (hc.stall_cnt !== e.cnt) begin
        errors++;
        $display("FAIL no_stall[%0d] stall_cnt got %0d want %0d", i, hc.stall_cnt, e.cnt);
      end
    end
  endtask

  task automatic test_redirect();
    in_t v[4];
    logic [8:0] c[4];
    logic [CNT_W-1:0] n[4];
    exp_t e;
    v[0] = f_lu(3'd3, 3'd2, 1'b1, 1'b1, 3'd3);
    v[0].redir = 1'b1; v[0].imem = 1'b1;       c[0] = C_REDIR; n[0] = 2'd0;
    v[1] = f_idle();                           c[1] = C_RUN;   n[1] = 2'd0;
    v[2] = f_idle(); v[2].imem = 1'b1;         c[2] = C_IMEM;  n[2] = 2'd0;
    v[3] = f_idle();                           c[3] = C_RUN;   n[3] = 2'd1;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      apply(v[i], c[i], n[i]);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (obs_ctl() !== e.ctl) begin
        errors++;
        $display("FAIL redirect[%0d] ctl got %b want %b", i, obs_ctl(), e.ctl);
      end
      checks++;
      if (hc.stall_cnt !== e.cnt) begin
        errors++;
        $display("FAIL redirect[%0d] stall_cnt got %0d want %0d", i, hc.stall_cnt, e.cnt);
      end
    end
  endtask

  task automatic test_dwait();
    in_t v[6];
    logic [8:0] c[6];
    logic [CNT_W-1:0] n[6];
    exp_t e;
    v[0] = f_mem(1'b0); c[0] = C_FRZ; n[0] = 2'd0;
    v[1] = f_mem(1'b0); c[1] = C_FRZ; n[1] = 2'd1;
    v[2] = f_mem(1'b0); c[2] = C_FRZ; n[2] = 2'd2;
    v[3] = f_mem(1'b1); c[3] = C_RUN; n[3] = 2'd3;
    v[4] = f_mem(1'b1); c[4] = C_RUN; n[4] = 2'd3;
    v[5] = f_idle();    c[5] = C_RUN; n[5] = 2'd3;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      apply(v[i], c[i], n[i]);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (obs_ctl() !== e.ctl) begin
        errors++;
        $display("FAIL dwait[%0d] ctl got %b want %b", i, obs_ctl(), e.ctl);
      end
      checks++;
      if (hc.stall_cnt !== e.cnt) begin
        errors++;
        $display("FAIL dwait[%0d] stall_cnt got %0d want %0d", i, hc.stall_cnt, e.cnt);
      end
    end
  endtask

  task automatic test_dwait_held();
    in_t v[8];
    logic [8:0] c[8];
    logic [CNT_W-1:0] n[8];
    exp_t e;
    v[0] = f_mem(1'b0); v[0].redir = 1'b1;                    c[0] = C_FRZ;   n[0] = 2'd0;
    v[1] = f_mem(1'b0); v[1].redir = 1'b1; v[1].halt = 1'b1;  c[1] = C_FRZ;   n[1] = 2'd1;
    v[2] = f_mem(1'b1); v[2].redir = 1'b1; v[2].halt = 1'b1;  c[2] = C_REDIR; n[2] = 2'd2;
    v[3] = f_idle();                                          c[3] = C_RUN;   n[3] = 2'd2;
    v[4] = f_lu(3'd6, 3'd1, 1'b1, 1'b0, 3'd6); v[4].macc = 1'b1;
                                                              c[4] = C_FRZ;   n[4] = 2'd2;
    v[5] = v[4]; v[5].dd = 1'b1;                              c[5] = C_LU;    n[5] = 2'd3;
    v[6] = f_lu(3'd6, 3'd1, 1'b1, 1'b0, 3'd6);                c[6] = C_LU;    n[6] = 2'd3;
    v[7] = f_idle();                                          c[7] = C_RUN;   n[7] = 2'd3;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      apply(v[i], c[i], n[i]);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (obs_ctl() !== e.ctl) begin
        errors++;
        $display("FAIL dwait_held[%0d] ctl got %b want %b", i, obs_ctl(), e.ctl);
      end
      checks++;
      if (hc.stall_cnt !== e.cnt) begin
        errors++;
        $display("FAIL dwait_held[%0d] stall_cnt got %0d want %0d", i, hc.stall_cnt, e.cnt);
      end
    end
  endtask

  task automatic test_reset_mid_dwait();
    in_t v[5];
    logic [8:0] c[5];
    logic [CNT_W-1:0] n[5];
    exp_t e;
    v[0] = f_mem(1'b0);                  c[0] = C_FRZ; n[0] = 2'd0;
    v[1] = f_mem(1'b0);                  c[1] = C_FRZ; n[1] = 2'd1;
    v[2] = f_mem(1'b0); v[2].rst = 1'b0; c[2] = C_RST; n[2] = 2'd2;
    v[3] = f_idle();                     c[3] = C_RUN; n[3] = 2'd0;
    v[4] = f_mem(1'b1);                  c[4] = C_RUN; n[4] = 2'd0;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      apply(v[i], c[i], n[i]);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (obs_ctl() !== e.ctl) begin
        errors++;
        $display("FAIL rst_dwait[%0d] ctl got %b want %b", i, obs_ctl(), e.ctl);
      end
      checks++;
      if (hc.stall_cnt !== e.cnt) begin
        errors++;
        $display("FAIL rst_dwait[%0d] stall_cnt got %0d want %0d", i, hc.stall_cnt, e.cnt);
      end
    end
  endtask

  task automatic test_halt();
    in_t v[12];
    logic [8:0] c[12];
    logic [CNT_W-1:0] n[12];
    exp_t e;
    for (int i = 0; i < 5; i++) begin
      v[i] = f_idle(); v[i].imem = 1'b1; c[i] = C_IMEM;
      n[i] = (i > 3) ? 2'd3 : 2'(i);
    end
    v[5]  = f_idle(); v[5].halt = 1'b1;           c[5]  = C_FRZ;    n[5]  = 2'd3;
    v[6]  = f_idle(); v[6].imem = 1'b1;           c[6]  = C_HALTED; n[6]  = 2'd3;
    v[7]  = f_lu(3'd2, 3'd2, 1'b1, 1'b1, 3'd2);   c[7]  = C_HALTED; n[7]  = 2'd3;
    v[8]  = f_mem(1'b0);                          c[8]  = C_HALTED; n[8]  = 2'd3;
    v[9]  = f_idle(); v[9].redir = 1'b1;          c[9]  = C_HALTED; n[9]  = 2'd3;
    v[10] = f_idle(); v[10].rst = 1'b0;           c[10] = C_RST;    n[10] = 2'd3;
    v[11] = f_idle();                             c[11] = C_RUN;    n[11] = 2'd0;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      apply(v[i], c[i], n[i]);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (obs_ctl() !== e.ctl) begin
        errors++;
        $display("FAIL halt[%0d] ctl got %b want %b", i, obs_ctl(), e.ctl);
      end
      checks++;
      if (hc.stall_cnt !== e.cnt) begin
        errors++;
        $display("FAIL halt[%0d] stall_cnt got %0d want %0d", i, hc.stall_cnt, e.cnt);
      end
    end
  endtask

  initial begin
    rst_n           = 1'b0;
    hc.id_read_r1   = '0;
    hc.id_read_r2   = '0;
    hc.id_uses_r1   = 1'b0;
    hc.id_uses_r2   = 1'b0;
    hc.ex_write_r   = '0;
    hc.ex_REG_WRITE = 1'b0;
    hc.ex_MEM_READ  = 1'b0;
    hc.ex_redirect  = 1'b0;
    hc.mem_access   = 1'b0;
    hc.dmem_done    = 1'b0;
    hc.imem_stall   = 1'b0;
    hc.wb_HALT      = 1'b0;
    test_reset();
    test_load_use();
    test_no_stall();
    test_redirect();
    test_dwait();
    test_dwait_held();
    test_reset_mid_dwait();
    test_halt();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete within 100000 ns");
    $fatal(1);
  end

endmodule
